// File: rtl/lcd_dma_axi_reader.sv
// lcd_dma_axi_reader: fixed-length AXI4 INCR read bursts on behalf of an LCD DMA requester.
// Define LCD_DMA_RESP_CHECK_EN to enable sticky RRESP/RLAST error checking on DMA_RD_ERR.
module lcd_dma_axi_reader #(
  parameter int         BURST_SIZE  = 8,
  parameter logic [3:0] ARCACHE_VAL = 4'b0011
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        DMA_START,
  input  logic [29:0] DMA_RD_ADDR,
  output logic        DMA_READY,
  output logic [31:0] DMA_RD_DATA,
  output logic        DMA_RD_DATA_VALID,
  output logic        DMA_RD_ERR,
  output logic [31:0] M_AXI_ARADDR,
  output logic [7:0]  M_AXI_ARLEN,
  output logic [2:0]  M_AXI_ARSIZE,
  output logic [1:0]  M_AXI_ARBURST,
  output logic [3:0]  M_AXI_ARCACHE,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RLAST,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state, state_nxt;
  logic [8:0] beat_cnt;
  logic ar_hs, r_hs, last_beat;
  assign ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs = M_AXI_RVALID & M_AXI_RREADY;
  assign last_beat = beat_cnt == 9'(BURST_SIZE - 1);
  assign M_AXI_ARLEN = 8'(BURST_SIZE - 1);
  assign M_AXI_ARSIZE = 3'b010;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARCACHE = ARCACHE_VAL;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = (state == IDLE && DMA_START) ? ADDR :
                (state == ADDR && ar_hs) ? DATA :
                (state == DATA && r_hs && last_beat) ? IDLE : state;
  end
  always_comb begin
    DMA_READY = state == IDLE;
    M_AXI_ARVALID = state == ADDR;
    M_AXI_RREADY = state == DATA;
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      M_AXI_ARADDR <= '0;
      beat_cnt <= '0;
      DMA_RD_DATA <= '0;
      DMA_RD_DATA_VALID <= 1'b0;
    end else begin
      if (state == IDLE && DMA_START) M_AXI_ARADDR <= {DMA_RD_ADDR, 2'b00};
      beat_cnt <= ar_hs ? 9'd0 : r_hs ? beat_cnt + 9'd1 : beat_cnt;
      if (r_hs) DMA_RD_DATA <= M_AXI_RDATA;
      DMA_RD_DATA_VALID <= r_hs;
    end
`ifdef LCD_DMA_RESP_CHECK_EN
  // RLAST must coincide exactly with the counter's final beat; completion still follows the counter
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) DMA_RD_ERR <= 1'b0;
    else if (r_hs && (M_AXI_RRESP != 2'b00 || M_AXI_RLAST != last_beat)) DMA_RD_ERR <= 1'b1;
`else
  logic unused_resp;
  assign unused_resp = ^{M_AXI_RRESP, M_AXI_RLAST};
  assign DMA_RD_ERR = 1'b0;
`endif
endmodule

// File: tb/tb_lcd_dma_axi_reader.sv
// tb_lcd_dma_axi_reader: scoreboard bench for lcd_dma_axi_reader with BURST_SIZE=8.
module tb_lcd_dma_axi_reader;
  localparam int BS = 8;
`ifdef LCD_DMA_RESP_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif
  logic        CLK = 1'b0, RESET = 1'b1, DMA_START = 1'b0;
  logic [29:0] DMA_RD_ADDR = '0;
  logic        DMA_READY, DMA_RD_DATA_VALID, DMA_RD_ERR, M_AXI_ARVALID, M_AXI_RREADY;
  logic [31:0] DMA_RD_DATA, M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic [3:0]  M_AXI_ARCACHE;
  logic        M_AXI_ARREADY = 1'b0, M_AXI_RLAST = 1'b0, M_AXI_RVALID = 1'b0;
  logic [31:0] M_AXI_RDATA = '0;
  logic [1:0]  M_AXI_RRESP = '0;
  int n_vec = 0, n_err = 0, ar_cnt = 0, w_cnt = 0;
  logic [31:0] q[$];

  lcd_dma_axi_reader #(.BURST_SIZE(BS), .ARCACHE_VAL(4'b0011)) dut (
    .CLK(CLK), .RESET(RESET), .DMA_START(DMA_START), .DMA_RD_ADDR(DMA_RD_ADDR),
    .DMA_READY(DMA_READY), .DMA_RD_DATA(DMA_RD_DATA), .DMA_RD_DATA_VALID(DMA_RD_DATA_VALID),
    .DMA_RD_ERR(DMA_RD_ERR), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARCACHE(M_AXI_ARCACHE),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA),
    .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK)
    if (M_AXI_ARVALID && M_AXI_ARREADY) ar_cnt <= ar_cnt + 1;

  always @(negedge CLK)
    if (DMA_RD_DATA_VALID) begin
      logic [31:0] e;
      n_vec++;
      w_cnt++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_valid: got data %h, expected no pulse", DMA_RD_DATA);
      end else begin
        e = q.pop_front();
        if (DMA_RD_DATA !== e) begin
          n_err++;
          $display("FAIL rd_data: got %h, expected %h", DMA_RD_DATA, e);
        end
      end
    end

  task automatic check_reset_outputs(input string tag);
    n_vec++;
    if ({DMA_READY, DMA_RD_DATA_VALID, DMA_RD_DATA, M_AXI_ARVALID, M_AXI_RREADY, M_AXI_ARADDR, DMA_RD_ERR}
        !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL %s: got rdy=%b v=%b d=%h arv=%b rr=%b ara=%h err=%b, expected 1 0 0 0 0 0 0",
               tag, DMA_READY, DMA_RD_DATA_VALID, DMA_RD_DATA, M_AXI_ARVALID, M_AXI_RREADY, M_AXI_ARADDR, DMA_RD_ERR);
    end
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    #1 RESET = 1'b1;
    #1 check_reset_outputs("reset_async");
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    q.delete();
  endtask

  task automatic run_burst(input logic [29:0] addr, input int ar_wait, input int gap,
                           input int err_beat, input int early_last, input bit poke);
    int t = 0, a0;
    logic [31:0] d;
    while (!DMA_READY && t < 50) begin
      @(posedge CLK);
      #1 t++;
    end
    n_vec++;
    if (DMA_READY !== 1'b1) begin
      n_err++;
      $display("FAIL ready_timeout: got %b, expected 1", DMA_READY);
    end
    a0 = ar_cnt;
    DMA_START = 1'b1;
    DMA_RD_ADDR = addr;
    @(posedge CLK);
    #1 DMA_START = 1'b0;
    DMA_RD_ADDR = 30'($urandom);
    n_vec++;
    if ({M_AXI_ARVALID, DMA_READY, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARCACHE, M_AXI_RREADY}
        !== {1'b1, 1'b0, addr, 2'b00, 8'(BS - 1), 3'b010, 2'b01, 4'b0011, 1'b0}) begin
      n_err++;
      $display("FAIL ar_issue: got arv=%b rdy=%b ara=%h len=%h sz=%h bu=%h ca=%h rr=%b, expected 1 0 %h %h 2 1 3 0",
               M_AXI_ARVALID, DMA_READY, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
               M_AXI_ARCACHE, M_AXI_RREADY, {addr, 2'b00}, 8'(BS - 1));
    end
    repeat (ar_wait) begin
      @(posedge CLK);
      #1 n_vec++;
      if (M_AXI_ARVALID !== 1'b1 || M_AXI_ARADDR !== {addr, 2'b00}) begin
        n_err++;
        $display("FAIL ar_hold: got arv=%b ara=%h, expected 1 %h", M_AXI_ARVALID, M_AXI_ARADDR, {addr, 2'b00});
      end
    end
    M_AXI_ARREADY = 1'b1;
    @(posedge CLK);
    #1 M_AXI_ARREADY = 1'b0;
    n_vec++;
    if (M_AXI_ARVALID !== 1'b0 || M_AXI_RREADY !== 1'b1) begin
      n_err++;
      $display("FAIL data_phase: got arv=%b rr=%b, expected 0 1", M_AXI_ARVALID, M_AXI_RREADY);
    end
    for (int i = 0; i < BS; i++) begin
      repeat (gap) begin
        @(posedge CLK);
        #1;
      end
      d = $urandom;
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA = d;
      M_AXI_RRESP = (i == err_beat) ? 2'b10 : 2'b00;
      M_AXI_RLAST = (i == BS - 1) || (i == early_last);
      q.push_back(d);
      if (poke && i == 3) begin
        DMA_START = 1'b1;
        DMA_RD_ADDR = 30'h3ff;
      end
      @(posedge CLK);
      #1 M_AXI_RVALID = 1'b0;
      M_AXI_RLAST = 1'b0;
      M_AXI_RRESP = 2'b00;
      DMA_START = 1'b0;
    end
    n_vec++;
    if ({DMA_READY, DMA_RD_DATA_VALID, M_AXI_ARADDR} !== {1'b1, 1'b1, addr, 2'b00} || ar_cnt != a0 + 1) begin
      n_err++;
      $display("FAIL burst_end: got rdy=%b v=%b ara=%h ars=%0d, expected 1 1 %h 1",
               DMA_READY, DMA_RD_DATA_VALID, M_AXI_ARADDR, ar_cnt - a0, {addr, 2'b00});
    end
    @(negedge CLK);
    #1 n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL words_pending: got %0d left, expected 0", q.size());
    end
  endtask

  task automatic test_reset();
    #2 check_reset_outputs("reset_initial");
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(posedge CLK);
    #1 check_reset_outputs("reset_released");
  endtask

  task automatic test_single();
    run_burst(30'h100, 0, 0, -1, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    run_burst(30'h2345, 5, 2, -1, -1, 1'b0);
  endtask

  task automatic test_ignored_start();
    run_burst(30'h0abc, 1, 0, -1, -1, 1'b1);
  endtask

  task automatic test_back_to_back();
    int w0 = w_cnt;
    run_burst(30'h11, 0, 0, -1, -1, 1'b0);
    run_burst(30'h19, 0, 1, -1, -1, 1'b0);
    n_vec++;
    if (w_cnt - w0 != 2 * BS) begin
      n_err++;
      $display("FAIL b2b_words: got %0d, expected %0d", w_cnt - w0, 2 * BS);
    end
  endtask

  task automatic test_reset_mid_burst();
    int w0;
    DMA_START = 1'b1;
    DMA_RD_ADDR = 30'h55;
    M_AXI_ARREADY = 1'b1;
    @(posedge CLK);
    #1 DMA_START = 1'b0;
    @(posedge CLK);
    #1 M_AXI_ARREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA = $urandom;
      q.push_back(M_AXI_RDATA);
      @(posedge CLK);
      #1;
    end
    M_AXI_RVALID = 1'b0;
    @(negedge CLK);
    #1 w0 = w_cnt;
    RESET = 1'b1;
    M_AXI_RVALID = 1'b1;
    #1 check_reset_outputs("reset_mid_burst");
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    M_AXI_RVALID = 1'b0;
    @(posedge CLK);
    #1 n_vec++;
    if (w_cnt != w0 || DMA_RD_DATA_VALID !== 1'b0 || DMA_READY !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset: got extra=%0d v=%b rdy=%b, expected 0 0 1", w_cnt - w0, DMA_RD_DATA_VALID, DMA_READY);
    end
    run_burst(30'h77, 0, 0, -1, -1, 1'b0);
  endtask

  task automatic test_resp_check();
    int w0;
    pulse_reset();
    run_burst(30'h40, 0, 0, 1, -1, 1'b0);
    n_vec++;
    if (DMA_RD_ERR !== CHK) begin
      n_err++;
      $display("FAIL err_rresp: got %b, expected %b", DMA_RD_ERR, CHK);
    end
    run_burst(30'h48, 0, 0, -1, -1, 1'b0);
    n_vec++;
    if (DMA_RD_ERR !== CHK) begin
      n_err++;
      $display("FAIL err_sticky: got %b, expected %b", DMA_RD_ERR, CHK);
    end
    pulse_reset();
    run_burst(30'h50, 0, 0, -1, -1, 1'b0);
    n_vec++;
    if (DMA_RD_ERR !== 1'b0) begin
      n_err++;
      $display("FAIL err_clean: got %b, expected 0", DMA_RD_ERR);
    end
    w0 = w_cnt;
    run_burst(30'h60, 0, 0, -1, 4, 1'b0);
    n_vec++;
    if (DMA_RD_ERR !== CHK || w_cnt - w0 != BS) begin
      n_err++;
      $display("FAIL err_early_last: got err=%b words=%0d, expected %b %0d", DMA_RD_ERR, w_cnt - w0, CHK, BS);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_burst();
    test_resp_check();
    repeat (2) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/lcd_dma_axi_reader.md
LCD_DMA_AXI_READER -- requirements
Module: lcd_dma_axi_reader

Interface
REQ-001 SHALL have parameter BURST_SIZE, default 8, giving 32-bit words per burst; legal values are powers of two from 1 to 256.
REQ-002 SHALL have parameter ARCACHE_VAL, default 4'b0011, giving the constant driven on M_AXI_ARCACHE.
REQ-003 CLK  in  1  sole clock; every signal is in this domain.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 DMA_START  in  1  one-cycle burst request, honoured only while DMA_READY=1.
REQ-006 DMA_RD_ADDR  in  30  word address of the burst, sampled with DMA_START.
REQ-007 DMA_READY  out  1  1 = idle and able to accept DMA_START.
REQ-008 DMA_RD_DATA  out  32  returned word, valid while DMA_RD_DATA_VALID=1.
REQ-009 DMA_RD_DATA_VALID  out  1  one cycle per returned word.
REQ-010 M_AXI_ARADDR  out  32  byte address, equal to {DMA_RD_ADDR,2'b00}.
REQ-011 M_AXI_ARLEN  out  8  constant BURST_SIZE-1.
REQ-012 M_AXI_ARSIZE / ARBURST / ARCACHE  out  3/2/4  constants 3'b010 / 2'b01 (INCR) / ARCACHE_VAL.
REQ-013 M_AXI_ARVALID  out  1; M_AXI_ARREADY  in  1  AXI4 read-address handshake.
REQ-014 M_AXI_RDATA  in  32; M_AXI_RRESP  in  2; M_AXI_RLAST  in  1; M_AXI_RVALID  in  1; M_AXI_RREADY  out  1  AXI4 read-data channel.
REQ-015 DMA_RD_ERR  out  1  sticky error flag, cleared only by RESET.

Function
REQ-016 SHALL implement the FSM states IDLE, ADDR and DATA.
REQ-017 IDLE: DMA_READY=1; on DMA_START=1, SHALL latch DMA_RD_ADDR, go to ADDR, and drop DMA_READY in the next cycle.
REQ-018 DMA_START while DMA_READY=0 SHALL be ignored, with no queuing.
REQ-019 ADDR: M_AXI_ARVALID=1 with ARADDR held stable; on ARVALID&ARREADY, SHALL clear the beat counter and go to DATA; ARVALID SHALL NOT drop before the handshake.
REQ-020 ARVALID SHALL first assert in the cycle after DMA_START, and the logic SHALL NOT wait on ARREADY before asserting it.
REQ-021 DATA: M_AXI_RREADY=1 constantly; each RVALID&RREADY beat SHALL register RDATA into DMA_RD_DATA and pulse DMA_RD_DATA_VALID in the following cycle (latency 1).
REQ-022 The beat counter SHALL be 9 bits wide; on the beat where the counter equals BURST_SIZE-1, the FSM SHALL return to IDLE, so DMA_READY=1 in the same cycle the last DMA_RD_DATA_VALID pulses.
REQ-023 RREADY SHALL be 0 in IDLE and ADDR.
REQ-024 Completion SHALL be decided by the beat counter only; RLAST SHALL NOT end a burst early.
REQ-025 Back-to-back: DMA_START in the cycle DMA_READY reasserts SHALL be accepted, with no idle gap needed.
REQ-026 Keeping bursts within 4 KB boundaries and address alignment is the upstream requester's responsibility; this block SHALL NOT split bursts.

Reset
REQ-027 On RESET=1, SHALL asynchronously force state IDLE, DMA_READY=1, DMA_RD_DATA_VALID=0, DMA_RD_DATA=0, M_AXI_ARVALID=0, M_AXI_RREADY=0, M_AXI_ARADDR=0, beat counter 0, DMA_RD_ERR=0.
REQ-028 Reset mid-burst SHALL abandon the transaction with no further DMA_RD_DATA_VALID; the interconnect is reset together with this block.
REQ-029 Outputs SHALL leave reset values only from the first CLK edge after RESET deasserts.

Configuration
REQ-030 With macro LCD_DMA_RESP_CHECK_EN defined, SHALL set DMA_RD_ERR on any beat with RRESP!=2'b00, with RLAST=1 on a non-final beat, or with RLAST=0 on the final beat; data SHALL still be forwarded.
REQ-031 With LCD_DMA_RESP_CHECK_EN undefined, SHALL tie DMA_RD_ERR to 0 and SHALL ignore RRESP and RLAST, with no check logic synthesised.

Verification
REQ-032 Single burst: DMA_START, addr 30'h100, ARREADY=1 -> ARVALID one cycle later, ARADDR=32'h400, ARLEN=7; 8 beats -> 8 VALID pulses, each 1 cycle after its beat, data in order; DMA_READY=1 on the 8th pulse.
REQ-033 Backpressure: ARREADY held 0 for 5 cycles -> ARVALID and ARADDR stable for all 5; RVALID gaps -> VALID pulses only on handshakes.
REQ-034 Ignored start: DMA_START during DATA -> no second AR and no corruption; back-to-back starts at DMA_READY edges -> 2 bursts, 16 words total.
REQ-035 Reset mid-burst after beat 3 -> all outputs at reset values immediately, no further VALID pulses, new burst then completes normally.
REQ-036 With LCD_DMA_RESP_CHECK_EN: RRESP=2'b10 on beat 2 -> DMA_RD_ERR=1 and sticky; early RLAST on beat 5 -> DMA_RD_ERR=1 and burst still 8 beats. Without the macro, the same stimulus -> DMA_RD_ERR=0.
